// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared types and constants for the phase accumulator / dds front end
package dds_pkg;

    localparam int CFG_ACC_DW = 32;

    typedef struct packed {
        logic [CFG_ACC_DW-1:0] offset;
        logic [CFG_ACC_DW-1:0] inc;
    } phase_cfg_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } acc_state_t;

    // x^16+x^14+x^13+x^11+1 in right-shifting form: feedback from bits 0,2,3,5
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

endpackage

// File: rtl/dds_lfsr.sv
// rtl/dds_lfsr.sv - 16-bit Fibonacci LFSR with step enable, low bits exposed as dither
module dds_lfsr
    import dds_pkg::*;
#(
    parameter int OUT_DW = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              step,
    output logic [OUT_DW-1:0] rnd
);

    logic [15:0] lfsr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr <= LFSR_SEED;
        end else if (step) begin
            lfsr <= {^(lfsr & LFSR_TAPS), lfsr[15:1]};
        end
    end

    assign rnd = lfsr[OUT_DW-1:0];

endmodule

// File: rtl/phase_accumulator.sv
// rtl/phase_accumulator.sv - NCO phase accumulator with offset, optional dither and stream output
module phase_accumulator
    import dds_pkg::*;
#(
    parameter int ACC_DW    = 32,
    parameter int PHASE_DW  = 16,
    parameter int DITHER    = 0,
    parameter int DITHER_DW = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2*ACC_DW-1:0]   s_axis_config_tdata,
    input  logic                  s_axis_config_tvalid,
    output logic                  s_axis_config_tready,
    input  logic                  enable,
    input  logic                  sync,
    output logic [PHASE_DW-1:0]   m_axis_phase_tdata,
    output logic                  m_axis_phase_tvalid,
    input  logic                  m_axis_phase_tready
);

    generate
        if (PHASE_DW > ACC_DW) begin : g_chk_width
            $error("phase_accumulator: PHASE_DW must not exceed ACC_DW");
        end
        if (DITHER != 0 && DITHER_DW > ACC_DW - PHASE_DW) begin : g_chk_dither
            $error("phase_accumulator: DITHER_DW exceeds the truncated bits");
        end
    endgenerate

    acc_state_t          state, state_nx;
    logic [ACC_DW-1:0]   acc, inc, offset, sh_inc, sh_off;
    logic [ACC_DW-1:0]   inc_eff, off_eff, acc_n, dith, sum;
    logic [PHASE_DW-1:0] tdata;
    logic                tvalid, cfg_pending, cfg_loaded, sync_pending;
    logic                start, advance, cfg_fire, cfg_apply;

    generate
        if (DITHER != 0) begin : g_dither
            logic [DITHER_DW-1:0] rnd;
            dds_lfsr #(.OUT_DW(DITHER_DW)) u_lfsr (
                .clk     (clk),
                .reset_n (reset_n),
                .step    (advance),
                .rnd     (rnd)
            );
            assign dith = ACC_DW'(rnd) << (ACC_DW - PHASE_DW - DITHER_DW);
        end else begin : g_no_dither
            assign dith = '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (!enable) state_nx = DRAIN;
            DRAIN:   if (enable) state_nx = RUN;
                     else if (!tvalid) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // A pending shadow lands at once when idle, otherwise only on an advance
    always_comb begin
        start     = (state == IDLE) && enable && cfg_loaded;
        advance   = ((state == RUN) || start) && (!tvalid || m_axis_phase_tready);
        cfg_fire  = s_axis_config_tvalid && !cfg_pending;
        cfg_apply = cfg_pending && (advance || (state == IDLE));
    end

    always_comb begin
        inc_eff = cfg_apply ? sh_inc : inc;
        off_eff = cfg_apply ? sh_off : offset;
        acc_n   = sync_pending ? '0 : acc;
        sum     = acc_n + off_eff + dith;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc          <= '0;
            inc          <= '0;
            offset       <= '0;
            sh_inc       <= '0;
            sh_off       <= '0;
            cfg_pending  <= 1'b0;
            cfg_loaded   <= 1'b0;
            sync_pending <= 1'b0;
            tvalid       <= 1'b0;
            tdata        <= '0;
        end else begin
            if (cfg_fire) begin
                sh_off      <= s_axis_config_tdata[2*ACC_DW-1:ACC_DW];
                sh_inc      <= s_axis_config_tdata[ACC_DW-1:0];
                cfg_pending <= 1'b1;
            end else if (cfg_apply) begin
                cfg_pending <= 1'b0;
            end
            if (cfg_apply) begin
                inc        <= sh_inc;
                offset     <= sh_off;
                cfg_loaded <= 1'b1;
            end
            if (sync)         sync_pending <= 1'b1;
            else if (advance) sync_pending <= 1'b0;
            if (advance) begin
                acc    <= acc_n + inc_eff;
                tdata  <= PHASE_DW'(sum >> (ACC_DW - PHASE_DW));
                tvalid <= 1'b1;
            end else if (m_axis_phase_tready) begin
                tvalid <= 1'b0;
            end
        end
    end

    assign s_axis_config_tready = !cfg_pending;
    assign m_axis_phase_tdata   = tdata;
    assign m_axis_phase_tvalid  = tvalid;

endmodule
